// File: rtl/cam_pkg.sv
// Shared types for the camera frame writer: FSM states, FIFO entry layout and
// the drop-counter saturation value.
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    CAPTURE,
    DRAIN
  } state_t;

  // Address field is sized for the widest frame buffer; the top narrows it.
  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [15:0]             data;
  } fifo_entry_t;

  localparam logic [15:0] DROP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head; when full, a push is still taken
// if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = head_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    // The head is either the entry being pushed into an emptying FIFO or the
    // already-stored entry at the next read pointer.
    if (count_q == CW'(pop_ok)) begin
      if (push_ok) head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Windows the reconstructed pixel stream, buffers {addr, data} pairs and writes
// them to a frame buffer. Define DOWNSAMPLE_2X_EN to keep only even/even pixels.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int ADDR_WIDTH   = 17,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    pixel_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
  input  logic [15:0]             pixel_data_in,
  input  logic                    mem_ready_in,
  output logic                    mem_we_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [15:0]             mem_data_out,
  output logic                    frame_done_out,
  output logic                    overflow_out,
  output logic [15:0]             drop_count_out
);

  localparam int PROD_W = VCOUNT_WIDTH + $clog2(H_ACTIVE) + 1;

  state_t                  state_q, state_d;
  logic [HCOUNT_WIDTH-1:0] h_eff;
  logic [VCOUNT_WIDTH-1:0] v_eff;
  logic                    keep_px, in_win, is_last, frame_start, capture;
  logic [PROD_W-1:0]       prod;
  logic                    s1_valid_q;
  fifo_entry_t             s1_q, head_e;
  logic                    fifo_full, fifo_empty, pop, drop;
  logic                    overflow_q;
  logic [15:0]             drop_cnt_q;
  logic                    unused_addr_hi;

`ifdef DOWNSAMPLE_2X_EN
  assign h_eff   = pixel_hcount_in >> 1;
  assign v_eff   = pixel_vcount_in >> 1;
  assign keep_px = !pixel_hcount_in[0] && !pixel_vcount_in[0];
`else
  assign h_eff   = pixel_hcount_in;
  assign v_eff   = pixel_vcount_in;
  assign keep_px = 1'b1;
`endif

  assign in_win      = keep_px && (h_eff < HCOUNT_WIDTH'(H_ACTIVE)) && (v_eff < VCOUNT_WIDTH'(V_ACTIVE));
  assign is_last     = (h_eff == HCOUNT_WIDTH'(H_ACTIVE - 1)) && (v_eff == VCOUNT_WIDTH'(V_ACTIVE - 1));
  assign frame_start = pixel_valid_in && (pixel_hcount_in == '0) && (pixel_vcount_in == '0);
  assign prod        = PROD_W'(v_eff) * PROD_W'(H_ACTIVE) + PROD_W'(h_eff);

  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    frame_done_out = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          capture = 1'b1;
          state_d = is_last ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (pixel_valid_in && in_win) begin
          capture = 1'b1;
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !s1_valid_q) begin
          frame_done_out = 1'b1;
          state_d        = WAIT_FRAME;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign pop  = mem_we_out && mem_ready_in;
  assign drop = s1_valid_q && fifo_full && !pop;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= WAIT_FRAME;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= capture;
      if (capture) begin
        s1_q.addr <= ENTRY_ADDR_W'(ADDR_WIDTH'(prod));
        s1_q.data <= pixel_data_in;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != DROP_COUNT_MAX) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .push_i     (s1_valid_q),
    .push_data_i(s1_q),
    .pop_i      (pop),
    .head_o     (head_e),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mem_we_out     = !fifo_empty;
  assign mem_addr_out   = ADDR_WIDTH'(head_e.addr);
  assign mem_data_out   = head_e.data;
  assign overflow_out   = overflow_q;
  assign drop_count_out = drop_cnt_q;
  assign unused_addr_hi = |(head_e.addr >> ADDR_WIDTH);

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed and randomized frames against a queue-based model of the expected
// frame-buffer writes (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4).
module tb_cam_frame_writer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FD = 4;
  localparam int HW = 11;
  localparam int VW = 10;
  localparam int AW = 17;
`ifdef DOWNSAMPLE_2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          pixel_valid_in;
  logic [HW-1:0] pixel_hcount_in;
  logic [VW-1:0] pixel_vcount_in;
  logic [15:0]   pixel_data_in;
  logic          mem_ready_in;
  logic          mem_we_out;
  logic [AW-1:0] mem_addr_out;
  logic [15:0]   mem_data_out;
  logic          frame_done_out;
  logic          overflow_out;
  logic [15:0]   drop_count_out;

  cam_frame_writer #(
    .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .H_ACTIVE(H), .V_ACTIVE(V),
    .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pixel_valid_in(pixel_valid_in),
    .pixel_hcount_in(pixel_hcount_in), .pixel_vcount_in(pixel_vcount_in),
    .pixel_data_in(pixel_data_in), .mem_ready_in(mem_ready_in),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
    .frame_done_out(frame_done_out), .overflow_out(overflow_out),
    .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_writes = 0;
  int  done_cnt = 0;
  int  exp_frames = 0;
  int  last_xfer_cyc = -10;
  bit  m_cap = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Spec-level pixel rule: which pixels land in the window and where.
  function automatic void model_px(input int h, input int v, output bit keep,
                                   output int addr, output bit last);
`ifdef DOWNSAMPLE_2X_EN
    keep = (h % 2 == 0) && (v % 2 == 0) && (h / 2 < H) && (v / 2 < V);
    addr = (v / 2) * H + (h / 2);
    last = (h / 2 == H - 1) && (v / 2 == V - 1);
`else
    keep = (h < H) && (v < V);
    addr = v * H + h;
    last = (h == H - 1) && (v == V - 1);
`endif
  endfunction

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (mem_we_out && mem_ready_in) begin
        wr_t e;
        chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr_out), 64'(e.addr));
          chk("wr_data", 64'(mem_data_out), 64'(e.data));
        end
        n_writes++;
        last_xfer_cyc = cyc;
      end
      if (frame_done_out) begin
        done_cnt++;
        chk("done_after_last_write", 64'(cyc), 64'(last_xfer_cyc + 1));
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic send_px(input int h, input int v, input logic [15:0] d, input bit dropped);
    bit keep, last;
    int addr;
    @(posedge clk_in); #1;
    pixel_valid_in  = 1'b1;
    pixel_hcount_in = HW'(h);
    pixel_vcount_in = VW'(v);
    pixel_data_in   = d;
    model_px(h, v, keep, addr, last);
    if (!m_cap) begin
      if (h == 0 && v == 0) m_cap = 1;
      else keep = 0;
    end
    if (m_cap && keep) begin
      if (!dropped) exp_q.push_back('{addr, int'(d)});
      if (last) begin
        m_cap = 0;
        exp_frames++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      pixel_valid_in = 1'b0;
    end
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 100) begin
      @(posedge clk_in);
      t++;
    end
    chk("frame_done_seen", 64'(done_cnt), 64'(start + 1));
    idle(2);
  endtask

  task automatic send_frame(input int first_idx, input logic [15:0] base, input bit junk, input bit rnd);
    for (int idx = first_idx; idx < SC * SC * H * V; idx++) begin
      int h = idx % (SC * H);
      int v = idx / (SC * H);
      logic [15:0] d = rnd ? 16'($urandom) : base + 16'(idx);
      send_px(h, v, d, 0);
      if (junk && idx == 2) begin
        send_px(SC * H, 0, 16'hbad0, 0);
        send_px(0, SC * V, 16'hbad1, 0);
      end
      if (rnd) begin
        if ($urandom_range(0, 3) == 0)
          send_px(SC * H + int'($urandom_range(0, 2)), int'($urandom_range(0, SC * V - 1)), 16'($urandom), 0);
        idle(int'($urandom_range(0, 2)));
      end
    end
    idle(1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_w;
    rst_in          = 1'b1;
    pixel_valid_in  = 1'b0;
    pixel_hcount_in = '0;
    pixel_vcount_in = '0;
    pixel_data_in   = '0;
    mem_ready_in    = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_we", 64'(mem_we_out), 64'd0);
    chk("rst_addr", 64'(mem_addr_out), 64'd0);
    chk("rst_data", 64'(mem_data_out), 64'd0);
    chk("rst_done", 64'(frame_done_out), 64'd0);
    chk("rst_overflow", 64'(overflow_out), 64'd0);
    chk("rst_drops", 64'(drop_count_out), 64'd0);
    rst_in = 1'b0;

    // Pixel ahead of the first frame start is discarded.
    send_px(2 * SC, 1 * SC, 16'hdead, 0);
    idle(5);
    chk("preframe_no_write", 64'(n_writes), 64'd0);

    // Two-cycle latency of the frame-start pixel, then the rest of the frame.
    send_px(0, 0, 16'h1000, 0);
    @(negedge clk_in);
    chk("latency_n", 64'(mem_we_out), 64'd0);
    @(posedge clk_in); #1;
    pixel_valid_in = 1'b0;
    @(negedge clk_in);
    chk("latency_n1", 64'(mem_we_out), 64'd0);
    @(negedge clk_in);
    chk("latency_n2", 64'(mem_we_out), 64'd1);
    chk("first_addr", 64'(mem_addr_out), 64'd0);
    send_frame(1, 16'h1000, 0, 0);
    chk("frame1_writes", 64'(n_writes), 64'(H * V));

    // Out-of-window pixels inside a frame.
    send_frame(0, 16'h1100, 1, 0);
    chk("frame2_writes", 64'(n_writes), 64'(2 * H * V));

    // Backpressure: six pixels into a four-deep buffer.
    mem_ready_in = 1'b0;
    for (int i = 0; i < 6; i++)
      send_px((i % H) * SC, (i / H) * SC, 16'h2000 + 16'(i), i >= FD);
    idle(3);
    chk("ovf_flag", 64'(overflow_out), 64'd1);
    chk("ovf_count", 64'(drop_count_out), 64'd2);
    chk("bp_we", 64'(mem_we_out), 64'd1);
    chk("bp_addr", 64'(mem_addr_out), 64'd0);
    chk("bp_data", 64'(mem_data_out), 64'h2000);
    idle(3);
    chk("bp_addr_hold", 64'(mem_addr_out), 64'd0);
    chk("bp_data_hold", 64'(mem_data_out), 64'h2000);
    mem_ready_in = 1'b1;
    idle(6);
    chk("bp_drained", 64'(n_writes), 64'(2 * H * V + FD));
    send_px(2 * SC, 1 * SC, 16'h2006, 0);
    send_px(3 * SC, 1 * SC, 16'h2007, 0);
    idle(1);
    wait_done();
    chk("ovf_count_kept", 64'(drop_count_out), 64'd2);

    // Asynchronous reset after three writes of a frame.
    base_w = n_writes;
    for (int i = 0; i < 5; i++)
      send_px((i % H) * SC, (i / H) * SC, 16'h3000 + 16'(i), 0);
    @(negedge clk_in); #1;
    chk("pre_reset_writes", 64'(n_writes), 64'(base_w + 3));
    rst_in = 1'b1;
    #1;
    chk("arst_we", 64'(mem_we_out), 64'd0);
    chk("arst_addr", 64'(mem_addr_out), 64'd0);
    chk("arst_data", 64'(mem_data_out), 64'd0);
    chk("arst_overflow", 64'(overflow_out), 64'd0);
    chk("arst_drops", 64'(drop_count_out), 64'd0);
    chk("arst_done", 64'(frame_done_out), 64'd0);
    pixel_valid_in = 1'b0;
    exp_q.delete();
    m_cap = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(3);
    send_frame(0, 16'h4000, 0, 0);

    // Randomized frames with leading junk, idle gaps and out-of-window pixels.
    for (int f = 0; f < 4; f++) begin
      send_px(1 + int'($urandom_range(0, SC * H - 2)), int'($urandom_range(0, SC * V - 1)), 16'($urandom), 0);
      idle(int'($urandom_range(0, 2)));
      send_frame(0, 16'h0, 0, 1);
    end

    idle(5);
    chk("frames_total", 64'(done_cnt), 64'(exp_frames));
    chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
    chk("drops_end", 64'(drop_count_out), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Stage directly downstream of the camera pixel reconstructor. It takes the reconstructed RGB565 pixel stream with its coordinates and keeps only the pixels inside an H_ACTIVE×V_ACTIVE window aligned to frame start. It converts each kept pixel to a linear frame-buffer address and buffers the address/data pairs in a small FIFO. It then issues them as BRAM-style writes with ready backpressure, and reports frame completion, overflow and dropped-pixel count.

## Interface
- HCOUNT_WIDTH, 11, width of pixel_hcount_in
- VCOUNT_WIDTH, 10, width of pixel_vcount_in
- H_ACTIVE, 320, stored pixels per line
- V_ACTIVE, 240, stored lines per frame
- ADDR_WIDTH, 17, frame-buffer address width; requires H_ACTIVE*V_ACTIVE ≤ 2^ADDR_WIDTH
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥ 2
- clk_in  input  1  system clock; the block's only clock
- rst_in  input  1  reset, asynchronous, active-high
- pixel_valid_in  input  1  one-cycle strobe per reconstructed pixel
- pixel_hcount_in  input  HCOUNT_WIDTH  pixel column
- pixel_vcount_in  input  VCOUNT_WIDTH  pixel row
- pixel_data_in  input  16  RGB565 pixel
- mem_ready_in  input  1  sink accepts a write this cycle
- mem_we_out  output  1  write request valid
- mem_addr_out  output  ADDR_WIDTH  write address
- mem_data_out  output  16  write data
- frame_done_out  output  1  one-cycle pulse when a full frame has been written
- overflow_out  output  1  sticky: at least one pixel dropped since reset
- drop_count_out  output  16  saturating count of dropped pixels

## Operation
- Reset values: every output is 0, the FIFO is empty, and the FSM is in WAIT_FRAME.
- A pixel is "in-window" when it satisfies both h < H_ACTIVE and v < V_ACTIVE.
- FSM:
  - WAIT_FRAME: discards all pixels. A valid pixel at (0,0) moves the FSM to CAPTURE, and that pixel is itself processed.
  - CAPTURE: each valid in-window pixel is pushed as {addr, data}; out-of-window pixels are ignored. The push of pixel (H_ACTIVE-1, V_ACTIVE-1) moves the FSM to DRAIN.
  - DRAIN: ignores pixel input. Once the FIFO is empty and no write is pending, frame_done_out pulses for one cycle and the FSM returns to WAIT_FRAME.
- A valid pixel at (0,0) arriving in CAPTURE restarts the frame: the FSM stays in CAPTURE, the pixel is pushed, and frame_done_out does not pulse.
- Address arithmetic: addr = v*H_ACTIVE + h. Compute the product at full width VCOUNT_WIDTH+$clog2(H_ACTIVE)+1, then truncate to ADDR_WIDTH. Register the result in one pipeline stage (stage 1) before the FIFO push.
- Overflow handling:
  - A push into a full FIFO with no pop in the same cycle drops the pixel.
  - Each drop sets overflow_out and increments drop_count_out, which saturates at 0xFFFF.
  - Both are cleared only by rst_in.
- Simultaneous push and pop on a full FIFO: the pop frees a slot and the push is accepted; nothing is dropped.
- Write handshake:
  - mem_we_out/addr/data present the FIFO head and are registered.
  - An entry transfers on any cycle where mem_we_out && mem_ready_in.
  - While mem_we_out is high and mem_ready_in is low, addr/data hold stable.
- Reset mid-frame: all state clears immediately, in-flight entries are lost, and no frame_done_out is generated.

## Timing
- Latency: pixel_valid_in is high in cycle N, into an empty FIFO with the output idle. Then mem_we_out is high in cycle N+2 (one cycle in stage 1, one cycle in the FIFO/output register).
- Throughput: one write per cycle while mem_ready_in is high.
- frame_done_out asserts in the cycle after the last entry transfers.
- drop_count_out and overflow_out update in the cycle after stage 1 attempts the dropped push.

## Configuration
- DOWNSAMPLE_2X_EN defined:
  - Keeps only pixels with h[0]==0 and v[0]==0.
  - Uses h>>1 and v>>1 for the window test and for addressing.
  - The frame's last pixel is (2*H_ACTIVE-2, 2*V_ACTIVE-2).
  - Frame start remains (0,0).
- DOWNSAMPLE_2X_EN undefined: full-resolution behaviour exactly as described above.

## Structure
- Shared package cam_pkg holds:
  - the FSM state typedef {WAIT_FRAME, CAPTURE, DRAIN}
  - the fifo-entry struct {addr, data}
  - the DROP_COUNT_MAX constant
- Sub-module sync_fifo:
  - single clock, asynchronous active-high reset
  - parameterised width and depth
  - push/pop/full/empty ports, registered head output
  - simultaneous push and pop allowed when full

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4.
- Full frame with mem_ready_in=1, pixels (0,0)…(3,1) with data 0x1000+index -> eight writes to addr 0..7 with matching data, then exactly one frame_done_out pulse.
- Pixels arriving before the first (0,0), e.g. (2,1) -> no write; writes begin only at the (0,0) pixel.
- Out-of-window pixels (4,0) and (0,2) inside a frame -> ignored, addresses unaffected.
- mem_ready_in held low across 6 consecutive pixels -> 2 drops, overflow_out=1, drop_count_out=2, head addr/data stable. Releasing ready then drains 4 writes in order.
- rst_in asserted mid-frame after 3 writes -> outputs 0 asynchronously. The next frame from (0,0) starts at addr 0.
- With DOWNSAMPLE_2X_EN and an 8×4 input frame -> eight writes to addr 0..7 carrying the even/even pixels, then frame_done_out after (6,2).
